// File: rtl/jtkunio_sndcmd_fifo.sv
// Command FIFO storage and pointers.
// The head entry is read combinationally so the sound CPU sees it during the whole access.
module jtkunio_sndcmd_fifo #(
  parameter int unsigned AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally in AW bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/jtkunio_sndcmd.sv
// Main-to-sound CPU command latch built as a small FIFO with status port and IRQ.
// Edge detection on the bus strobes makes each CPU access push/pop exactly once.
module jtkunio_sndcmd #(
  parameter int unsigned AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_wr,
  input  logic [7:0] main_data,
  input  logic       rd_cs,
  input  logic       st_cs,
  output logic [7:0] dout,
  output logic       snd_irq,
  output logic       full
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic          wr_q;
  logic          wr_armed;
  logic          rd_q;
  logic          st_q;
  logic          ovf;
  logic          ovf_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          push_req;
  logic          pop_req;
  logic          st_fall;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic [7:0]    head;
  logic [2:0]    cnt3;

  // wr_armed blocks a strobe already high when reset releases until it drops once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      wr_armed <= 1'b0;
      rd_q     <= 1'b0;
      st_q     <= 1'b0;
      count    <= '0;
      full     <= 1'b0;
      snd_irq  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      wr_q     <= main_wr;
      wr_armed <= wr_armed | ~main_wr;
      rd_q     <= rd_cs;
      st_q     <= st_cs;
      count    <= count_nx;
      full     <= (count_nx == CW'(DEPTH));
      snd_irq  <= ~empty;
      ovf      <= ovf_nx;
    end
  end

  // A simultaneous pop frees a slot, so a push to a full FIFO is still accepted.
  always_comb begin
    push_req = main_wr & ~wr_q & wr_armed;
    pop_req  = rd_q & ~rd_cs;
    st_fall  = st_q & ~st_cs;
    empty    = (count == '0);
    do_pop   = pop_req & ~empty;
    do_push  = push_req & (~full | do_pop);
    count_nx = count;
    if (do_push && !do_pop)      count_nx = count + CW'(1);
    else if (do_pop && !do_push) count_nx = count - CW'(1);
    ovf_nx = (push_req & full & ~do_pop) | (ovf & ~st_fall);
  end

  if (AW >= 2) begin : g_cnt_wide
    assign cnt3 = count[2:0];
  end else begin : g_cnt_narrow
    assign cnt3 = 3'(count);
  end

  always_comb begin
    dout = 8'hFF;
    if (rd_cs)      dout = empty ? 8'hFF : head;
    else if (st_cs) dout = {ovf, full, 3'b000, cnt3};
  end

  jtkunio_sndcmd_fifo #(.AW(AW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (do_push),
    .pop  (do_pop),
    .din  (main_data),
    .head (head)
  );

endmodule

// File: doc/jtkunio_sndcmd.md
JTKUNIO_SNDCMD -- requirements
Module: jtkunio_sndcmd

Interface
REQ-001 SHALL have parameter AW, default 2, meaning FIFO address width (depth = 2**AW entries).
REQ-002 SHALL have port clk, input, 1, system clock (24 MHz); it is the only clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port main_wr, input, 1, main-CPU sound-command write strobe (level, may last many clk cycles).
REQ-005 SHALL have port main_data, input, 8, main-CPU command byte, valid while main_wr is high.
REQ-006 SHALL have port rd_cs, input, 1, sound-CPU command-read select (level).
REQ-007 SHALL have port st_cs, input, 1, sound-CPU status-read select (level).
REQ-008 SHALL have port dout, output, 8, sound-CPU read data.
REQ-009 SHALL have port snd_irq, output, 1, active-high IRQ to sound CPU.
REQ-010 SHALL have port full, output, 1, FIFO-full flag to the main side.

Function
REQ-011 SHALL register main_wr and treat only a 0->1 transition as a push request, so one write cycle pushes exactly once.
REQ-012 SHALL, on a push request when not full, store main_data at the write pointer and increment it with wrap-around modulo 2**AW.
REQ-013 SHALL, on a push request when full and no pop in the same cycle, discard the byte and set sticky flag ovf.
REQ-014 SHALL register rd_cs and treat a 1->0 transition as a pop request, so the head stays stable for the whole read access.
REQ-015 SHALL, on a pop request when not empty, advance the read pointer with wrap-around; a pop when empty SHALL change no state.
REQ-016 SHALL, on simultaneous push and pop in one cycle, perform both, leave count unchanged, and accept the push even when full.
REQ-017 SHALL keep count in AW+1 bits, range 0..2**AW; full = (count == 2**AW), empty = (count == 0).
REQ-018 SHALL drive dout combinationally: rd_cs -> head entry (8'hFF if empty); st_cs -> {ovf, full, 3'b0, count[2:0]} (count zero-extended if AW<2); neither -> 8'hFF; rd_cs has priority over st_cs.
REQ-019 SHALL clear ovf on the 1->0 transition of st_cs; if a new overflow occurs in that same cycle, ovf SHALL stay set.
REQ-020 SHALL drive snd_irq from a register equal to !empty, i.e. high one clk after the first push and low one clk after the last pop.
REQ-021 SHALL register full; it is updated in the same clk edge as count.

Reset
REQ-022 SHALL, while rst is high, force pointers and count to 0, ovf 0, snd_irq 0, full 0, and the edge-detect registers to 0; FIFO storage contents need not be cleared.
REQ-023 SHALL discard any push or pop in progress when rst asserts mid-operation; after release, a main_wr already held high SHALL NOT push until it returns low and rises again.

Structure
REQ-024 SHALL use no shared package; depth derives locally from AW.
REQ-025 SHALL optionally place storage and pointers in one sub-module, jtkunio_sndcmd_fifo; edge detection and status logic stay in the top.

Verification
REQ-026 SHALL cover: reset, then main_wr high for 40 clk with data 8'h3A -> count 1, snd_irq high after 1 clk, rd_cs reads 8'h3A, falling rd_cs -> count 0, snd_irq low next clk.
REQ-027 SHALL cover: push 8'h01..8'h05 with AW=2 -> first four stored, full=1, ovf=1; st_cs reads 8'hC4; after st_cs falls, ovf=0 and a second status read gives 8'h44.
REQ-028 SHALL cover: with 4 entries, push 8'h77 and rd_cs falling in the same cycle -> 8'h77 accepted, count stays 4, ovf stays 0.
REQ-029 SHALL cover: pop on empty FIFO -> count stays 0, dout 8'hFF during rd_cs, snd_irq stays 0.
REQ-030 SHALL cover: push 6 bytes, pop 6 bytes interleaved -> pointers wrap, data order preserved.
REQ-031 SHALL cover: rst asserted with main_wr held high and 2 entries stored -> count 0, snd_irq 0; no push after release until main_wr toggles low then high.
